fetch_queue_unit: RTL and testbench

- Instruction fetch stage directly downstream of the predict unit.
- Accepts fetch packets (start address plus instruction count) over a valid/ready handshake and issues sequential word reads to the 1-cycle-latency inst SRAM.
- Buffers returned instructions, tagged with their PCs, in a FIFO that feeds decode over a valid/ready handshake.
- A backend flush discards all buffered and in-flight work.

---
 rtl/fetch_queue_unit_if.sv | 29 ++
 rtl/fetch_queue_unit.sv | 152 +++++++++++++++
 tb/tb_fetch_queue_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_unit_if.sv
// Bundles the predict, inst SRAM and decode-side signals of the fetch queue unit.
// master: the fetch queue unit itself; slave: its surrounding pipeline/SRAM.
interface fetch_queue_unit_if;
  logic        pred_valid;
  logic [31:0] pred_addr;
  logic [1:0]  pred_num;
  logic        pred_ready;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_word;
  logic        flush;

  modport master (
    input  pred_valid, pred_addr, pred_num, inst_sram_rdata, inst_ready, flush,
    output pred_ready, inst_sram_we, inst_sram_addr, inst_sram_wdata,
           inst_valid, inst_pc, inst_word
  );

  modport slave (
    output pred_valid, pred_addr, pred_num, inst_sram_rdata, inst_ready, flush,
    input  pred_ready, inst_sram_we, inst_sram_addr, inst_sram_wdata,
           inst_valid, inst_pc, inst_word
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Fetch queue: turns predict packets into sequential inst SRAM reads and queues PC-tagged words for decode.
// Optional FETCH_PERF_CNT_EN adds perf_inst_cnt / perf_stall_cnt outputs.
//   state | meaning
//   IDLE  | no packet in progress; may accept when the queue has room for 4 words
//   ISSUE | presenting one SRAM read address per cycle until the packet is exhausted
module fetch_queue_unit #(
  parameter int          QUEUE_DEPTH = 8,
  parameter logic [31:0] RESET_PC    = 32'h1C000000
) (
  input logic clk,
  input logic rst,
  fetch_queue_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_inst_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = CW + 2;
  localparam logic [OW-1:0] CAP = OW'(QUEUE_DEPTH - 4);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t      state_q, state_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [2:0]  rem_q, rem_d;
  logic [31:0] last_addr_q;
  logic [31:0] resp_pc_q;
  logic        resp_pending_q;

  logic [31:0]   mem_pc   [QUEUE_DEPTH];
  logic [31:0]   mem_word [QUEUE_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic [OW-1:0] occ;
  logic          accept, issue, push, pop;

  // Occupancy counts queued words plus every word issued or still to be issued.
  always_comb begin
    occ = OW'(count_q) + OW'(resp_pending_q);
    if (state_q == ISSUE) occ = occ + OW'(rem_q);
  end

  assign bus.pred_ready = (state_q == IDLE) && !bus.flush && !rst && (occ <= CAP);
  assign accept = bus.pred_valid && bus.pred_ready;
  assign issue  = (state_q == ISSUE) && !bus.flush && !rst;
  assign push   = resp_pending_q;
  assign pop    = bus.inst_valid && bus.inst_ready;

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    if (bus.flush) begin
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            cur_addr_d = bus.pred_addr;
            rem_d      = {1'b0, bus.pred_num} + 3'd1;
            state_d    = ISSUE;
          end
        end
        ISSUE: begin
          cur_addr_d = cur_addr_q + 32'd4;
          rem_d      = rem_q - 3'd1;
          if (rem_q == 3'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cur_addr_q     <= '0;
      rem_q          <= '0;
      last_addr_q    <= RESET_PC;
      resp_pc_q      <= '0;
      resp_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_addr_q     <= cur_addr_d;
      rem_q          <= rem_d;
      resp_pending_q <= issue;
      if (issue) begin
        last_addr_q <= cur_addr_q;
        resp_pc_q   <= cur_addr_q;
      end
    end
  end

  // The address bus holds its last value whenever nothing is being issued.
  assign bus.inst_sram_addr  = issue ? cur_addr_q : last_addr_q;
  assign bus.inst_sram_we    = 1'b0;
  assign bus.inst_sram_wdata = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_word[i] <= '0;
      end
    end else if (bus.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_pc[wr_ptr_q]   <= resp_pc_q;
        mem_word[wr_ptr_q] <= bus.inst_sram_rdata;
        wr_ptr_q           <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.inst_valid = (count_q != '0);
  assign bus.inst_pc    = mem_pc[rd_ptr_q];
  assign bus.inst_word  = mem_word[rd_ptr_q];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst || bus.flush)
    !(push && !pop && (count_q == CW'(QUEUE_DEPTH))));

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_inst_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pop && !bus.flush) perf_inst_cnt <= perf_inst_cnt + 32'd1;
      if (!bus.inst_valid && !bus.flush) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios plus random traffic, checked against a packet-level model.
module tb_fetch_queue_unit;
  localparam int          D   = 8;
  localparam logic [31:0] RPC = 32'h1C000000;
  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_unit_if bus();
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_inst_cnt, perf_stall_cnt;
`endif

  fetch_queue_unit #(.QUEUE_DEPTH(D), .RESET_PC(RPC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_inst_cnt(perf_inst_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // 1-cycle-latency SRAM whose content is a function of the address.
  always @(posedge clk) bus.inst_sram_rdata <= bus.inst_sram_addr ^ KEY;

  typedef struct {
    logic [31:0] pc;
    int          vis;
  } ent_t;

  ent_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          e, busy_until, pkt_t, dut_acc;
  logic [31:0] pkt_base, last_addr, m_inst, m_stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, e);
    end
  endtask

  // One clock: check outputs against the model, then advance the model on the edge.
  task automatic step();
    logic        exp_valid, exp_ready, issuing, popv;
    logic [31:0] exp_addr;
    #1;
    exp_valid = (exp_q.size() > 0) && (exp_q[0].vis <= e);
    exp_ready = (e >= busy_until) && !bus.flush && !rst && (exp_q.size() + 4 <= D);
    issuing   = (e + 1 > pkt_t) && (e + 1 <= busy_until) && !bus.flush && !rst;
    exp_addr  = issuing ? pkt_base + 32'(4 * (e - pkt_t)) : last_addr;
    chk("inst_valid", 32'(bus.inst_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("inst_pc", bus.inst_pc, exp_q[0].pc);
      chk("inst_word", bus.inst_word, exp_q[0].pc ^ KEY);
    end
    chk("pred_ready", 32'(bus.pred_ready), 32'(exp_ready));
    chk("sram_addr", bus.inst_sram_addr, exp_addr);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_inst", perf_inst_cnt, m_inst);
    chk("perf_stall", perf_stall_cnt, m_stall);
`endif
    if (bus.pred_valid && bus.pred_ready) dut_acc++;
    popv = exp_valid && bus.inst_ready && !bus.flush && !rst;
    @(posedge clk);
    if (rst) begin
      m_inst  = '0;
      m_stall = '0;
    end else begin
      if (popv) m_inst = m_inst + 32'd1;
      if (!exp_valid && !bus.flush) m_stall = m_stall + 32'd1;
    end
    e++;
    if (rst) begin
      exp_q.delete();
      busy_until = 0;
      last_addr  = RPC;
    end else if (bus.flush) begin
      exp_q.delete();
      busy_until = 0;
    end else begin
      if (issuing) last_addr = exp_addr;
      if (popv) void'(exp_q.pop_front());
      if (bus.pred_valid && exp_ready) begin
        pkt_t      = e;
        pkt_base   = bus.pred_addr;
        busy_until = e + int'(bus.pred_num) + 1;
        for (int k = 0; k <= int'(bus.pred_num); k++)
          exp_q.push_back('{pc: bus.pred_addr + 32'(4 * k), vis: e + k + 2});
      end
    end
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] addr, input logic [1:0] num);
    bus.pred_valid = 1'b1;
    bus.pred_addr  = addr;
    bus.pred_num   = num;
    step();
    bus.pred_valid = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.flush      = 1'b0;
    bus.pred_valid = 1'b0;
    bus.pred_addr  = '0;
    bus.pred_num   = '0;
    bus.inst_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    e = 0; busy_until = 0; pkt_t = 0; pkt_base = '0; dut_acc = 0;
    last_addr = RPC; m_inst = '0; m_stall = '0;

    chk("rst_pc", bus.inst_pc, 32'h0);
    chk("rst_word", bus.inst_word, 32'h0);
    chk("rst_we", 32'(bus.inst_sram_we), 32'h0);
    chk("rst_wdata", bus.inst_sram_wdata, 32'h0);
    step();
    rst = 1'b0;

    // Single 4-word packet, decode always ready.
    bus.inst_ready = 1'b1;
    offer(RPC, 2'd3);
    repeat (10) step();

    // Back-pressure: only two 4-word packets fit.
    bus.inst_ready = 1'b0;
    dut_acc = 0;
    for (int i = 0; i < 16; i++) begin
      bus.pred_valid = 1'b1;
      bus.pred_addr  = 32'h1C001000 + 32'(16 * i);
      bus.pred_num   = 2'd3;
      step();
    end
    bus.pred_valid = 1'b0;
    chk("bp_accepts", 32'(dut_acc), 32'd2);
    bus.inst_ready = 1'b1;
    repeat (10) step();
    dut_acc = 0;
    bus.pred_valid = 1'b1;
    bus.pred_addr  = 32'h1C002000;
    bus.pred_num   = 2'd3;
    repeat (2) step();
    bus.pred_valid = 1'b0;
    chk("bp_resume", 32'(dut_acc), 32'd1);
    repeat (8) step();

    // Flush while the second word's data is due.
    bus.inst_ready = 1'b0;
    offer(32'h1C000040, 2'd3);
    repeat (2) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_valid", 32'(bus.inst_valid), 32'h0);
    step();
    bus.inst_ready = 1'b1;
    offer(32'h1C000100, 2'd3);
    repeat (8) step();

    // Reset in the middle of issuing.
    offer(32'h1C000200, 2'd3);
    step();
    rst = 1'b1;
    step();
    chk("rst_mid_valid", 32'(bus.inst_valid), 32'h0);
    chk("rst_mid_ready", 32'(bus.pred_ready), 32'h0);
    chk("rst_mid_addr", bus.inst_sram_addr, RPC);
    step();
    rst = 1'b0;
    offer(32'h1C000300, 2'd2);
    repeat (8) step();

    // Random traffic with alternating decode pressure, occasional flush/reset and address wrap.
    for (int c = 0; c < 600; c++) begin
      bus.pred_valid = ($urandom % 4) != 0;
      bus.pred_num   = 2'($urandom % 4);
      if (($urandom % 8) == 0) bus.pred_addr = {28'hFFFFFFF, 2'($urandom % 4), 2'b00};
      else bus.pred_addr = {$urandom, 2'b00} & 32'hFFFF_FFFC;
      if (((c / 50) % 2) == 0) bus.inst_ready = ($urandom % 4) != 0;
      else bus.inst_ready = ($urandom % 4) == 0;
      bus.flush = ($urandom % 40) == 0;
      rst       = ($urandom % 200) == 0;
      step();
    end
    bus.pred_valid = 1'b0;
    bus.flush      = 1'b0;
    rst            = 1'b0;
    bus.inst_ready = 1'b1;
    repeat (12) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
